// File: rtl/arb_pkg.sv
// Shared definitions for the OR-request round-robin arbiter.
//   state_t : FSM state encoding (IDLE = no owner, GRANT = one owner)
//   MAX_N   : largest supported requester count
//   onehot  : binary index -> one-hot vector of MAX_N bits
package arb_pkg;

    localparam int unsigned MAX_N = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
        return {{(MAX_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search, purely combinational.
//   i_req   : request vector
//   i_ptr   : index where the search starts (wraps N-1 -> 0)
//   i_excl  : mask of requesters that may not be picked
//   o_found : some requester outside i_excl is active
//   o_sel   : index of the first eligible requester at or after i_ptr
module rr_pick #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_ptr,
    input  logic [N-1:0] i_excl,
    output logic         o_found,
    output logic [2:0]   o_sel
);

    logic [N-1:0] w_cand;

    assign w_cand = i_req & ~i_excl;

    // Each candidate's distance from the pointer (modulo N); the nearest wins.
    always_comb begin
        int unsigned v_dist;
        int unsigned v_best;
        o_found = 1'b0;
        o_sel   = '0;
        v_dist  = 0;
        v_best  = N;
        for (int unsigned i = 0; i < N; i++) begin
            v_dist = (i >= 32'(i_ptr)) ? (i - 32'(i_ptr)) : (i + N - 32'(i_ptr));
            if (w_cand[i] && (v_dist < v_best)) begin
                v_best  = v_dist;
                o_found = 1'b1;
                o_sel   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/or_req_arbiter.sv
// Round-robin arbiter placed in front of a resource gated by the OR of all
// request lines. Grants one owner at a time, rotates fairly, and preempts an
// owner that has held the grant for MAX_HOLD cycles while others wait.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req       : request vector, bit i held high while requester i needs access
//   any_req   : combinational OR of req
//   gnt       : registered one-hot grant (zero = no owner)
//   gnt_valid : registered, high when gnt is non-zero
//   gnt_id    : registered binary owner index, 0 when no owner
//   preempt   : registered one-cycle pulse when the hold timer moved the grant
module or_req_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = 3,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         any_req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [2:0]   gnt_id,
    output logic         preempt
);

    // Last count value before the timer fires; with MAX_HOLD=0 the counter stays 0.
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(N - 1);

    state_t           r_state;
    logic [N-1:0]     r_gnt;
    logic             r_gnt_valid;
    logic [2:0]       r_gnt_id;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_preempt;

    state_t           w_state_nxt;
    logic [N-1:0]     w_gnt_nxt;
    logic [2:0]       w_id_nxt;
    logic [2:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pre_nxt;
    logic             w_take;

    logic             w_found;
    logic [2:0]       w_sel;
    logic [N-1:0]     w_sel_oh;
    logic [2:0]       w_ptr_after;
    logic             w_owner_req;

    assign any_req     = |req;
    assign w_owner_req = |(req & r_gnt);
    assign w_sel_oh    = N'(onehot(w_sel));
    assign w_ptr_after = (w_sel == LAST_IDX) ? '0 : (w_sel + 3'd1);

    // Excluding the current owner (r_gnt is zero in IDLE) turns o_found into
    // "someone else is waiting" while a grant is held.
    rr_pick #(
        .N (N)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .i_excl  (r_gnt),
        .o_found (w_found),
        .o_sel   (w_sel)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_id_nxt    = r_gnt_id;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_pre_nxt   = 1'b0;
        w_take      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_take = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    if (w_found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_id_nxt    = '0;
                    end
                end else if ((MAX_HOLD != 0) && (r_cnt == HOLD_LAST) && w_found) begin
                    w_take    = 1'b1;
                    w_pre_nxt = 1'b1;
                end else if (r_cnt != HOLD_LAST) begin
                    // Saturates: a lone owner parks at HOLD_LAST and is moved
                    // on the first cycle anyone else asks.
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_take) begin
            w_state_nxt = ST_GRANT;
            w_gnt_nxt   = w_sel_oh;
            w_id_nxt    = w_sel;
            w_ptr_nxt   = w_ptr_after;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_gnt_id    <= w_id_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_preempt   <= w_pre_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_or_req_arbiter.sv
// Self-checking bench for or_req_arbiter (N=3, MAX_HOLD=4).
module tb_or_req_arbiter;

    localparam int N        = 3;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         any_req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [2:0]   gnt_id;
    logic         preempt;

    int n_checks = 0;
    int n_pass   = 0;

    or_req_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .any_req   (any_req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int owner;   // -1 = nobody
        int ptr;
        int cnt;
        int pre;
    } mstate_t;

    mstate_t m = '{owner: -1, ptr: 0, cnt: 0, pre: 0};

    function automatic bit bit_of(input logic [N-1:0] r, input int i);
        logic [N-1:0] t;
        t = r >> i;
        return t[0];
    endfunction

    function automatic int search(input logic [N-1:0] r, input int from, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (from + k) % N;
            if (bit_of(r, i) && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [N-1:0] r);
        mstate_t n;
        int pick;
        int other;
        n     = s;
        n.pre = 0;
        pick  = search(r, s.ptr, -1);
        if (s.owner < 0 || !bit_of(r, s.owner)) begin
            if (pick >= 0) begin
                n.owner = pick;
                n.cnt   = 0;
                n.ptr   = (pick + 1) % N;
            end else begin
                n.owner = -1;
            end
        end else begin
            other = search(r, s.ptr, s.owner);
            if (s.cnt == MAX_HOLD - 1 && other >= 0) begin
                n.owner = other;
                n.cnt   = 0;
                n.ptr   = (other + 1) % N;
                n.pre   = 1;
            end else if (s.cnt < MAX_HOLD - 1) begin
                n.cnt = s.cnt + 1;
            end
        end
        return n;
    endfunction

    function automatic int mgnt(input mstate_t s);
        return (s.owner < 0) ? 0 : (1 << s.owner);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{owner: -1, ptr: 0, cnt: 0, pre: 0};
        else        m <= model_next(m, req);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("cmp_gnt",      int'(gnt),       mgnt(m));
            chk("cmp_valid",    int'(gnt_valid), (m.owner >= 0) ? 1 : 0);
            chk("cmp_id",       int'(gnt_id),    (m.owner >= 0) ? m.owner : 0);
            chk("cmp_preempt",  int'(preempt),   m.pre);
            chk("cmp_any_req",  int'(any_req),   (req != '0) ? 1 : 0);
            chk("gnt_onehot0",  int'($onehot0(gnt)), 1);
            chk("valid_vs_gnt", int'(gnt_valid), int'(|gnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [N-1:0] t3_req [7] = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011};
    logic [N-1:0] t3_exp [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};

    initial begin
        rst_n = 1'b0;
        req   = '0;

        // 1. reset then idle
        repeat (2) tick();
        chk("t1_gnt",     int'(gnt),       0);
        chk("t1_valid",   int'(gnt_valid), 0);
        chk("t1_any_req", int'(any_req),   0);
        rst_n = 1'b1;

        // 2. single request, drop, next search from ptr=2
        req = 3'b010;
        tick();
        chk("t2_gnt",       int'(gnt),    3'b010);
        chk("t2_id",        int'(gnt_id), 1);
        chk("t2_model_gnt", mgnt(m),      3'b010);
        repeat (4) tick();
        req = 3'b000;
        tick();
        chk("t2_drop_gnt",   int'(gnt),       0);
        chk("t2_drop_valid", int'(gnt_valid), 0);
        req = 3'b101;
        tick();
        chk("t2_ptr2_gnt", int'(gnt),    3'b100);
        chk("t2_ptr2_id",  int'(gnt_id), 2);
        req = 3'b000;
        tick();

        // 3. simultaneous requests, back-to-back rotation
        do_reset();
        for (int s = 0; s < 7; s++) begin
            req = t3_req[s];
            tick();
            chk("t3_gnt",   int'(gnt),       int'(t3_exp[s]));
            chk("t3_valid", int'(gnt_valid), 1);
        end
        chk("t3_model_gnt", mgnt(m), 3'b001);
        req = 3'b000;
        tick();

        // 4. preemption by hold timer
        do_reset();
        req = 3'b001;
        tick();
        chk("t4_first", int'(gnt), 3'b001);
        req = 3'b011;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t4_hold_gnt", int'(gnt),     3'b001);
            chk("t4_hold_pre", int'(preempt), 0);
        end
        tick();
        chk("t4_pre_gnt",   int'(gnt),     3'b010);
        chk("t4_pre_pulse", int'(preempt), 1);
        chk("t4_model_pre", m.pre,         1);
        tick();
        chk("t4_after_gnt", int'(gnt),     3'b010);
        chk("t4_after_pre", int'(preempt), 0);
        req = 3'b001;
        tick();
        chk("t4_regain", int'(gnt), 3'b001);
        // asynchronous reset mid-grant
        rst_n = 1'b0;
        #1;
        chk("t4_async_gnt",   int'(gnt),       0);
        chk("t4_async_valid", int'(gnt_valid), 0);
        chk("t4_async_id",    int'(gnt_id),    0);
        req = '0;
        tick();
        rst_n = 1'b1;

        // 5. lone owner never preempted
        req = 3'b100;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t5_gnt", int'(gnt),     3'b100);
            chk("t5_pre", int'(preempt), 0);
        end
        req = 3'b000;
        tick();

        // 6. request sweep
        for (int r = 0; r < 8; r++) begin
            req = 3'(r);
            repeat (10) tick();
            chk("t6_any_req", int'(any_req), (r != 0) ? 1 : 0);
        end
        req = 3'b000;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
